// File: rtl/ula_exec_unit.sv
// ula_exec_unit: execution stage for the opcode controller.
// ADD/SUB/MUL finish in one cycle; DIV/MOD run a restoring divider that
// retires one quotient bit per cycle. One operation is in flight at a time,
// and the result is held until the consumer takes it.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE. A result is handed
// off on a rising edge where out_valid and out_ready are both high. While
// out_valid is high, result and flags do not change. A producer whose
// in_valid is not consumed must keep it asserted.
module ula_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ula_operation,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             error,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             error_q;

  logic             accept;
  logic             start_div;
  logic             div_done;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   exec_result;
  logic               exec_overflow;
  logic               exec_error;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign error     = error_q;

  assign accept    = in_valid && in_ready;
  // Only a real divide with a nonzero divisor needs the iterative path;
  // divide-by-zero resolves in the single-cycle EXEC state.
  assign start_div = ((ula_operation == OP_DIV) || (ula_operation == OP_MOD)) &&
                     (operand_b != '0);
  assign div_done  = (cnt_q == CW'(WIDTH));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> EXEC or DIV -> HOLD -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = start_div ? S_DIV : S_EXEC;
      S_EXEC: state_d = S_HOLD;
      S_DIV:  if (div_done) state_d = S_HOLD;
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle results, computed from the latched operands.
  always_comb begin
    sum           = {1'b0, a_q} + {1'b0, b_q};
    prod          = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    exec_result   = '0;
    exec_overflow = 1'b0;
    exec_error    = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_result   = sum[WIDTH-1:0];
        exec_overflow = sum[WIDTH];
      end
      OP_SUB: begin
        exec_result   = a_q - b_q;
        exec_overflow = (a_q < b_q);
      end
      OP_MUL: begin
        exec_result   = prod[WIDTH-1:0];
        exec_overflow = |prod[2*WIDTH-1:WIDTH];
      end
      // EXEC only sees DIV/MOD when the divisor is zero.
      OP_DIV: begin
        exec_result = '1;
        exec_error  = 1'b1;
      end
      OP_MOD: begin
        exec_result = a_q;
        exec_error  = 1'b1;
      end
      default: begin
        exec_result = '0;
        exec_error  = 1'b1;
      end
    endcase
  end

  // One restoring-division step: shift in the next dividend bit and
  // subtract the divisor if it fits.
  always_comb begin
    shifted   = {rem_q, quot_q[WIDTH-1]};
    trial     = shifted - {1'b0, b_q};
    rem_next  = shifted[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next  = trial[WIDTH-1:0];
      quot_next = {quot_q[WIDTH-2:0], 1'b1};
    end
  end

  // Datapath: latch on accept, iterate in DIV, load the output registers
  // when leaving EXEC or DIV.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= ula_operation;
            a_q    <= operand_a;
            b_q    <= operand_b;
            rem_q  <= '0;
            quot_q <= operand_a;
            cnt_q  <= '0;
          end
        end
        S_EXEC: begin
          result_q   <= exec_result;
          overflow_q <= exec_overflow;
          error_q    <= exec_error;
        end
        S_DIV: begin
          if (div_done) begin
            result_q   <= (op_q == OP_DIV) ? quot_q : rem_q;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
          end else begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
